// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
package serial_subtractor_pkg;

    // Controller states; the encoding is fixed so IDLE is the all-zero state.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Number of DIGIT-wide slices in a WIDTH-bit operand.
    function automatic int slice_count(input int width, input int digit);
        return width / digit;
    endfunction

    // Slice counter width: enough to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational ripple-borrow subtractor slice: d = x - y - bi over DIGIT bits.
module sub_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic borrow;

    // Ripple the borrow LSB to MSB using the 1-bit full-subtractor cell.
    always_comb begin
        // NOTE: every signal written here gets a value before any conditional
        // or loop touches it, so no latch can be inferred.
        borrow = bi;
        d      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]   = x[i] ^ y[i] ^ borrow;
            borrow = (borrow & ~(x[i] ^ y[i])) | (~x[i] & y[i]);
        end
        bo = borrow;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB slice
// first, with a start/busy/done handshake and borrow/overflow/zero flags.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = slice_count(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);

    // Refuse to build a configuration whose width is not a whole number of slices.
    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_width_check
        $error("serial_subtractor: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
               WIDTH, DIGIT);
    end

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             finish;
    logic             last;

    // Operands shift right by one slice per RUN cycle, so the active slice is
    // always the low DIGIT bits.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             borrow_reg;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;

    // Result slices shift in from the top, so after N slices acc is aligned.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [DIGIT-1:0] slice_d;
    logic             slice_bo;

    sub_slice #(.DIGIT(DIGIT)) u_slice (
        .x  (a_reg[DIGIT-1:0]),
        .y  (b_reg[DIGIT-1:0]),
        .bi (borrow_reg),
        .d  (slice_d),
        .bo (slice_bo)
    );

    assign last     = (cnt == CW'(N - 1));
    assign busy     = (state == S_RUN);
    assign acc_next = (acc >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: accept start only in IDLE, finish on the last slice.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture and per-slice shifting of operands, borrow and partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            a_msb      <= a[WIDTH-1];
            b_msb      <= b[WIDTH-1];
            cnt        <= '0;
            acc        <= '0;
        end else if (state == S_RUN) begin
            a_reg      <= a_reg >> DIGIT;
            b_reg      <= b_reg >> DIGIT;
            borrow_reg <= slice_bo;
            acc        <= acc_next;
            if (!last) cnt <= cnt + CW'(1);
        end
    end

    // Publish the result and flags only on completion; they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                diff <= acc_next;
                bout <= slice_bo;
                ovf  <= (a_msb ^ b_msb) & (acc_next[WIDTH-1] ^ a_msb);
                zero <= (acc_next == '0);
            end
        end
    end

endmodule
